// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and status-flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, N cycles after start.
// product is the combinational next accumulator so the owner can capture it on the done cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic           busy;
  logic [CW-1:0]  count;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;

  always_comb begin
    product = mplier[0] ? (acc + mcand) : acc;
    done    = busy && (count == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready intake; single-cycle ops complete in one cycle,
// MUL hands off to the iterative multiplier and blocks intake until it finishes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ain,
  input  logic [N-1:0] bin,
  input  logic [2:0]   aluop,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         wr_en,
  output logic [2:0]   statusout
);

  state_t         state;
  logic [N-1:0]   op_res;
  logic           op_v;
  logic [2:0]     op_flags;
  logic [N-1:0]   sum;
  logic [N-1:0]   diff;
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_prod;
  logic [2:0]     mul_flags;

  assign in_ready  = (state == IDLE);
  assign mul_start = in_valid && in_ready && (aluop == OP_MUL);

  alu_mul_seq #(.N(N), .CW(CW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (ain),
    .b       (bin),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    sum    = ain + bin;
    diff   = ain - bin;
    op_res = '0;
    op_v   = 1'b0;
    case (aluop)
      OP_ADD: begin
        op_res = sum;
        op_v   = (ain[N-1] == bin[N-1]) && (sum[N-1] != ain[N-1]);
      end
      OP_SUB, OP_CMP: begin
        op_res = diff;
        op_v   = (ain[N-1] != bin[N-1]) && (diff[N-1] != ain[N-1]);
      end
      OP_AND:  op_res = ain & bin;
      OP_NOT:  op_res = ~bin;
      OP_OR:   op_res = ain | bin;
      OP_XOR:  op_res = ain ^ bin;
      default: op_res = '0;
    endcase
    op_flags         = '0;
    op_flags[FLAG_Z] = (op_res == '0);
    op_flags[FLAG_N] = op_res[N-1];
    op_flags[FLAG_V] = op_v;
    // Overflow on MUL means the low half alone does not represent the product.
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_prod[N-1:0] == '0);
    mul_flags[FLAG_N] = mul_prod[N-1];
    mul_flags[FLAG_V] = |mul_prod[2*N-1:N];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      result    <= '0;
      statusout <= '0;
    end else begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (aluop == OP_MUL) begin
              state <= MUL;
            end else begin
              out_valid <= 1'b1;
              wr_en     <= (aluop != OP_CMP);
              statusout <= op_flags;
              // CMP only updates flags; the result register keeps the last writeback value.
              if (aluop != OP_CMP) result <= op_res;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            wr_en     <= 1'b1;
            result    <= mul_prod[N-1:0];
            statusout <= mul_flags;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push hand-computed responses, a monitor pops on out_valid.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 16;

  typedef struct {
    logic [N-1:0] res;
    logic [2:0]   flags;
    logic         wr;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] ain, bin;
  logic [2:0]   aluop;
  logic         out_valid;
  logic [N-1:0] result;
  logic         wr_en;
  logic [2:0]   statusout;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .aluop     (aluop),
    .out_valid (out_valid),
    .result    (result),
    .wr_en     (wr_en),
    .statusout (statusout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got result %h status %b, no response pending", result, statusout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_status"}, 32'(statusout), 32'(e.flags));
        chk({e.name, "_wr_en"}, 32'(wr_en), 32'(e.wr));
      end
    end
  end

  // Present one request, hold it until accepted, then push the expected response.
  task automatic issue(input string name, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] er, input logic [2:0] ef,
                       input logic ew);
    int guard;
    exp_t e;
    aluop = op; ain = a; bin = b; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) begin
      checks++; failures++;
      $display("FAIL %s_accept_timeout: in_ready %b expected 1", name, in_ready);
    end
    e.res = er; e.flags = ef; e.wr = ew; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mul_latency(input string name);
    int low;
    low = 0;
    while (in_ready !== 1'b1 && low < 40) begin
      low++;
      @(posedge clk); #1;
    end
    chk({name, "_busy_cycles"}, 32'(low), 32'(N));
    chk({name, "_done_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ain = '0; bin = '0; aluop = OP_ADD;
    cycles(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_result", 32'(result), 32'd0);
      chk("idle_status", 32'(statusout), 32'd0);
      chk("idle_wr_en", 32'(wr_en), 32'd0);
      cycles(1);
    end

    issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1'b1);
    chk("add_latency", 32'(out_valid), 32'd1);
    cycles(1);
    chk("single_pulse", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle ops.
    issue("sub", OP_SUB, 16'h084E, 16'h0847, 16'h0007, 3'b000, 1'b1);
    issue("not", OP_NOT, 16'h1111, 16'h4000, 16'hBFFF, 3'b010, 1'b1);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    issue("and", OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 3'b010, 1'b1);
    issue("or", OP_OR, 16'h0F00, 16'h00F0, 16'h0FF0, 3'b000, 1'b1);
    issue("xor", OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b001, 1'b1);
    issue("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1'b1);
    issue("add_prior", OP_ADD, 16'h1000, 16'h0234, 16'h1234, 3'b000, 1'b1);
    issue("cmp_eq", OP_CMP, 16'h2492, 16'h2492, 16'h1234, 3'b001, 1'b0);
    cycles(2);
    chk("hold_result", 32'(result), 32'h1234);
    chk("hold_status", 32'(statusout), 32'b001);

    issue("mul_small", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 3'b000, 1'b1);
    mul_latency("mul_small");
    cycles(1);
    issue("mul_wrap", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 3'b101, 1'b1);
    mul_latency("mul_wrap");
    cycles(1);
    issue("mul_ffff", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b100, 1'b1);
    mul_latency("mul_ffff");
    cycles(1);

    // Abort a MUL with reset; its response must never appear.
    aluop = OP_MUL; ain = 16'h0003; bin = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy", 32'(in_ready), 32'd0);
    cycles(4);
    reset = 1'b1;
    in_valid = 1'b1; aluop = OP_ADD; ain = 16'h0001; bin = 16'h0001;
    cycles(1);
    reset = 1'b0; in_valid = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_status", 32'(statusout), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    cycles(N + 4);
    chk("abort_still_idle", 32'(in_ready), 32'd1);
    chk("abort_result_held", 32'(result), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
